// File: rtl/clk_rate_switcher_if.sv
// Purpose: control/status bundle between the rate-requesting logic and clk_rate_switcher.
// Signals:
//   run        level; 1 = generate output, 0 = stop at the next period boundary
//   rate_sel   requested rate (0/1/2 valid, 3 illegal)
//   sel_valid  rate request valid
//   sel_ready  switcher can accept a rate request this cycle
//   cur_sel    rate currently in effect
//   clk_out    divided square wave
//   tick       1-cycle pulse on the last clk_in cycle of each output period
//   sel_err    1-cycle pulse one cycle after an accepted illegal rate_sel
// Modports: master = requester/consumer side, slave = switcher side.
interface clk_rate_switcher_if;
    logic       run;
    logic [1:0] rate_sel;
    logic       sel_valid;
    logic       sel_ready;
    logic [1:0] cur_sel;
    logic       clk_out;
    logic       tick;
    logic       sel_err;

    modport master (
        output run, rate_sel, sel_valid,
        input  sel_ready, cur_sel, clk_out, tick, sel_err
    );

    modport slave (
        input  run, rate_sel, sel_valid,
        output sel_ready, cur_sel, clk_out, tick, sel_err
    );
endinterface

// File: rtl/clk_rate_switcher.sv
// Purpose: glitch-free divider producing a square wave at one of three selectable rates
//          from clk_in. Rate changes and stops only take effect at a period boundary.
// Ports:
//   clk_in  system clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     clk_rate_switcher_if.slave (run, rate_sel, sel_valid in;
//           sel_ready, cur_sel, clk_out, tick, sel_err out)
// clk_out, tick, sel_err and cur_sel are registered; sel_ready is a decode of the
// registered state and the run level, since a run drop must refuse a request that cycle.
module clk_rate_switcher #(
    parameter int unsigned DIV0 = 5000,
    parameter int unsigned DIV1 = 1000,
    parameter int unsigned DIV2 = 1316,
    parameter int unsigned CW   = 13
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    clk_rate_switcher_if.slave   bus
);

    localparam int unsigned SW = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Period length for a rate select; the illegal code never reaches cur_sel.
    function automatic logic [CW-1:0] div_of(input logic [SW-1:0] sel);
        case (sel)
            2'd1:    div_of = CW'(DIV1);
            2'd2:    div_of = CW'(DIV2);
            default: div_of = CW'(DIV0);
        endcase
    endfunction

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [SW-1:0]  r_cur_sel;
    logic [SW-1:0]  r_pend_sel;
    logic           r_clk_out;
    logic           r_tick;
    logic           r_sel_err;

    state_t         w_nxt_state;
    logic [CW-1:0]  w_nxt_cnt;
    logic [SW-1:0]  w_nxt_sel;
    logic [SW-1:0]  w_nxt_pend;
    logic           w_nxt_err;
    logic           w_nxt_clk_out;
    logic           w_nxt_tick;

    logic [CW-1:0]  w_div_cur;
    logic [CW-1:0]  w_div_nxt;
    logic [CW-1:0]  w_cnt_inc;
    logic           w_at_end;
    logic           w_ready;
    logic           w_accept;
    logic           w_illegal;

    assign w_div_cur = div_of(r_cur_sel);
    assign w_at_end  = (r_cnt == (w_div_cur - CW'(1)));
    assign w_cnt_inc = w_at_end ? '0 : (r_cnt + CW'(1));
    assign w_ready   = (r_state == S_IDLE) || ((r_state == S_RUN) && bus.run);
    assign w_accept  = bus.sel_valid && w_ready;
    assign w_illegal = (bus.rate_sel == 2'd3);

    // Next-state, counter and rate-select decisions.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_sel   = r_cur_sel;
        w_nxt_pend  = r_pend_sel;
        w_nxt_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_nxt_cnt = '0;
                if (w_accept) begin
                    if (w_illegal) w_nxt_err = 1'b1;
                    else           w_nxt_sel = bus.rate_sel;
                end
                if (bus.run) w_nxt_state = S_RUN;
            end

            S_RUN: begin
                w_nxt_cnt = w_cnt_inc;
                if (!bus.run) begin
                    // Dropping run on the last cycle of a period needs no drain.
                    w_nxt_state = w_at_end ? S_IDLE : S_STOP;
                end else if (w_accept) begin
                    if (w_illegal) begin
                        w_nxt_err = 1'b1;
                    end else if (bus.rate_sel != r_cur_sel) begin
                        if (w_at_end) begin
                            // Request lands on the boundary itself: switch now.
                            w_nxt_sel = bus.rate_sel;
                        end else begin
                            w_nxt_pend  = bus.rate_sel;
                            w_nxt_state = S_DRAIN;
                        end
                    end
                end
            end

            S_DRAIN: begin
                w_nxt_cnt = w_cnt_inc;
                if (w_at_end) begin
                    w_nxt_sel   = r_pend_sel;
                    w_nxt_state = bus.run ? S_RUN : S_IDLE;
                end
            end

            S_STOP: begin
                w_nxt_cnt = w_cnt_inc;
                if (bus.run)       w_nxt_state = S_RUN;
                else if (w_at_end) w_nxt_state = S_IDLE;
            end

            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with cnt.
    assign w_div_nxt     = div_of(w_nxt_sel);
    assign w_nxt_clk_out = (w_nxt_state != S_IDLE) && (w_nxt_cnt < (w_div_nxt >> 1));
    assign w_nxt_tick    = (w_nxt_state != S_IDLE) && (w_nxt_cnt == (w_div_nxt - CW'(1)));

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cur_sel  <= '0;
            r_pend_sel <= '0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
            r_sel_err  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_cur_sel  <= w_nxt_sel;
            r_pend_sel <= w_nxt_pend;
            r_clk_out  <= w_nxt_clk_out;
            r_tick     <= w_nxt_tick;
            r_sel_err  <= w_nxt_err;
        end
    end

    assign bus.sel_ready = w_ready;
    assign bus.cur_sel   = r_cur_sel;
    assign bus.clk_out   = r_clk_out;
    assign bus.tick      = r_tick;
    assign bus.sel_err   = r_sel_err;

endmodule
